// File: rtl/tempo_transport.sv
// Transport controller and sub-tick scheduler: start/stop/pause sequencing, position tracking
// with bar looping. Define TEMPO_TRANSPORT_SWING_EN to add i_swing_clks (longer odd rows).
module tempo_transport #(
  parameter int unsigned SUBTICKS     = 8,
  parameter int unsigned ROWS_PER_BAR = 16,
  parameter int unsigned BAR_BITS     = 4,
  parameter int unsigned DIV_BITS     = 24,
  parameter int unsigned GATE_OFF_SUB = 6,
  localparam int unsigned SUB_W       = $clog2(SUBTICKS),
  localparam int unsigned ROW_W       = $clog2(ROWS_PER_BAR)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_pause,
  input  logic [DIV_BITS-1:0] i_tick_div,
  input  logic                i_loop_en,
  input  logic [BAR_BITS-1:0] i_loop_start_bar,
  input  logic [BAR_BITS-1:0] i_loop_end_bar,
`ifdef TEMPO_TRANSPORT_SWING_EN
  input  logic [DIV_BITS-1:0] i_swing_clks,
`endif
  output logic                o_subtick_stb,
  output logic                o_row_stb,
  output logic                o_gate_on_stb,
  output logic                o_gate_off_stb,
  output logic [SUB_W-1:0]    o_subtick,
  output logic [ROW_W-1:0]    o_row,
  output logic [BAR_BITS-1:0] o_bar,
  output logic                o_running,
  output logic                o_song_end
);

  localparam int unsigned POS_W = BAR_BITS + ROW_W + SUB_W;

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [DIV_BITS-1:0] r_cnt, w_cnt_d;
  logic [SUB_W-1:0]    r_sub, w_sub_d;
  logic [ROW_W-1:0]    r_row, w_row_d;
  logic [BAR_BITS-1:0] r_bar, w_bar_d;
  logic                r_subtick_stb, r_row_stb, r_gate_off_stb, r_song_end, r_running;
  logic                w_stb, w_reload, w_song_end_d, w_last;
  logic [DIV_BITS-1:0] w_base, w_reload_even, w_reload_odd;
  logic [POS_W-1:0]    w_pos_inc;

  // A zero divider behaves as one: a strobe every cycle.
  always_comb begin
    w_base        = (i_tick_div == '0) ? DIV_BITS'(1) : i_tick_div;
    w_reload_even = w_base - DIV_BITS'(1);
  end

`ifdef TEMPO_TRANSPORT_SWING_EN
  logic [DIV_BITS:0]   w_swing_sum;
  logic [DIV_BITS-1:0] w_swing_per;

  always_comb begin
    w_swing_sum = {1'b0, i_tick_div} + {1'b0, i_swing_clks};
    w_swing_per = w_swing_sum[DIV_BITS] ? '1 : w_swing_sum[DIV_BITS-1:0];
    if (w_swing_per == '0) begin
      w_swing_per = DIV_BITS'(1);
    end
    w_reload_odd = w_swing_per - DIV_BITS'(1);
  end
`else
  assign w_reload_odd = w_reload_even;
`endif

  // Position is one mixed-radix counter; power-of-2 fields carry for free.
  assign w_pos_inc = {r_bar, r_row, r_sub} + POS_W'(1);
  assign w_last    = (r_sub == '1) && (r_row == '1) && (r_bar == i_loop_end_bar);

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_sub_d      = r_sub;
    w_row_d      = r_row;
    w_bar_d      = r_bar;
    w_stb        = 1'b0;
    w_reload     = 1'b0;
    w_song_end_d = 1'b0;

    if (i_stop) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
      w_sub_d   = '0;
      w_row_d   = '0;
      w_bar_d   = '0;
    end else if (i_start) begin
      w_state_d = StRun;
      w_sub_d   = '0;
      w_row_d   = '0;
      w_bar_d   = '0;
      w_stb     = 1'b1;
      w_reload  = 1'b1;
    end else begin
      case (r_state)
        StRun, StPause: begin
          // A paused cycle never counts, so the strobe gap grows by exactly the pause length.
          if (i_pause) begin
            w_state_d = StPause;
          end else begin
            w_state_d = StRun;
            if (r_cnt != '0) begin
              w_cnt_d = r_cnt - DIV_BITS'(1);
            end else if (w_last && !i_loop_en) begin
              w_state_d    = StDone;
              w_song_end_d = 1'b1;
            end else begin
              w_stb    = 1'b1;
              w_reload = 1'b1;
              if (w_last) begin
                w_sub_d = '0;
                w_row_d = '0;
                w_bar_d = i_loop_start_bar;
              end else begin
                {w_bar_d, w_row_d, w_sub_d} = w_pos_inc;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end

    // Period belongs to the sub-tick just entered, hence the new row's parity.
    if (w_reload) begin
      w_cnt_d = w_row_d[0] ? w_reload_odd : w_reload_even;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_sub          <= '0;
      r_row          <= '0;
      r_bar          <= '0;
      r_subtick_stb  <= 1'b0;
      r_row_stb      <= 1'b0;
      r_gate_off_stb <= 1'b0;
      r_song_end     <= 1'b0;
      r_running      <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_sub          <= w_sub_d;
      r_row          <= w_row_d;
      r_bar          <= w_bar_d;
      r_subtick_stb  <= w_stb;
      r_row_stb      <= w_stb && (w_sub_d == '0);
      r_gate_off_stb <= w_stb && (w_sub_d == SUB_W'(GATE_OFF_SUB));
      r_song_end     <= w_song_end_d;
      r_running      <= (w_state_d == StRun) || (w_state_d == StPause);
    end
  end

  assign o_subtick_stb  = r_subtick_stb;
  assign o_row_stb      = r_row_stb;
  assign o_gate_on_stb  = r_row_stb;
  assign o_gate_off_stb = r_gate_off_stb;
  assign o_subtick      = r_sub;
  assign o_row          = r_row;
  assign o_bar          = r_bar;
  assign o_running      = r_running;
  assign o_song_end     = r_song_end;

endmodule

// File: tb/tb_tempo_transport.sv
// Directed bench for tempo_transport (SUBTICKS=8, ROWS_PER_BAR=4); expected strobe events are
// queued with their cycle numbers and matched as the DUT emits them.
module tb_tempo_transport;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_start = 1'b0, i_stop = 1'b0, i_pause = 1'b0, i_loop_en = 1'b0;
  logic [23:0] i_tick_div = 24'd4;
  logic [3:0]  i_loop_start_bar = 4'd0, i_loop_end_bar = 4'd1;
`ifdef TEMPO_TRANSPORT_SWING_EN
  logic [23:0] i_swing_clks = 24'd0;
`endif
  logic        o_subtick_stb, o_row_stb, o_gate_on_stb, o_gate_off_stb, o_running, o_song_end;
  logic [2:0]  o_subtick;
  logic [1:0]  o_row;
  logic [3:0]  o_bar;

  tempo_transport #(
    .SUBTICKS    (8),
    .ROWS_PER_BAR(4),
    .BAR_BITS    (4),
    .DIV_BITS    (24),
    .GATE_OFF_SUB(6)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .i_stop          (i_stop),
    .i_pause         (i_pause),
    .i_tick_div      (i_tick_div),
    .i_loop_en       (i_loop_en),
    .i_loop_start_bar(i_loop_start_bar),
    .i_loop_end_bar  (i_loop_end_bar),
`ifdef TEMPO_TRANSPORT_SWING_EN
    .i_swing_clks    (i_swing_clks),
`endif
    .o_subtick_stb   (o_subtick_stb),
    .o_row_stb       (o_row_stb),
    .o_gate_on_stb   (o_gate_on_stb),
    .o_gate_off_stb  (o_gate_off_stb),
    .o_subtick       (o_subtick),
    .o_row           (o_row),
    .o_bar           (o_bar),
    .o_running       (o_running),
    .o_song_end      (o_song_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [14:0] vec;
  } ev_t;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  c0;

  // {subtick_stb, row_stb, gate_on, gate_off, song_end, running, subtick, row, bar}
  function automatic logic [14:0] obs_vec();
    return {o_subtick_stb, o_row_stb, o_gate_on_stb, o_gate_off_stb, o_song_end, o_running,
            o_subtick, o_row, o_bar};
  endfunction

  // Linear position index -> expected strobe vector (8 sub-ticks, 4 rows, 32 per bar).
  function automatic logic [14:0] pos_vec(input int idx);
    logic [2:0] s;
    logic [1:0] r;
    logic [3:0] b;
    s = 3'(idx % 8);
    r = 2'((idx / 8) % 4);
    b = 4'(idx / 32);
    return {1'b1, s == 3'd0, s == 3'd0, s == 3'd6, 1'b0, 1'b1, s, r, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [14:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    sb.push_back(e);
  endtask

  // Queue n strobes for a start during cycle c_start; loop_mode wraps bar 1 end to bar 1.
  task automatic push_seq(input int c_start, input int n, input int per_e, input int per_o,
                          input bit loop_mode);
    int t;
    int idx;
    t = c_start + 1;
    for (int k = 0; k < n; k++) begin
      idx = (loop_mode && k >= 64) ? 32 + ((k - 64) % 32) : k;
      push(t, pos_vec(idx));
      t += (((idx / 8) % 2) == 1) ? per_o : per_e;
    end
  endtask

  task automatic tick();
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (o_subtick_stb || o_row_stb || o_gate_on_stb || o_gate_off_stb || o_song_end) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'(obs_vec()), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_vec", 32'(obs_vec()), 32'(e.vec));
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk("missing_strobe", 32'(obs_vec()), 32'(e.vec));
    end
  endtask

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    #10;
    chk("reset_outputs", 32'(obs_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // tick_div=4: strobes every 4 cycles, gate-off on sub-tick 6, row 1 after 32 cycles
    i_tick_div = 24'd4;
    c0 = cyc;
    push_seq(c0, 10, 4, 4, 1'b0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (39) tick();
    chk("row_after_32", 32'(o_row), 32'd1);
    chk("running_mid", 32'(o_running), 32'd1);

    // Asynchronous reset mid-run, then stay quiet
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(obs_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("idle_after_reset", 32'(obs_vec()), 32'd0);

    // tick_div=0 acts as 1
    i_tick_div = 24'd0;
    c0 = cyc;
    push_seq(c0, 6, 1, 1, 1'b0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (5) tick();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("stop_clears", 32'(obs_vec()), 32'd0);

    // Finish at bar 1 end: 64 strobes, then song_end with position held
    i_tick_div = 24'd1;
    i_loop_en  = 1'b0;
    i_loop_end_bar = 4'd1;
    c0 = cyc;
    push_seq(c0, 64, 1, 1, 1'b0);
    push(c0 + 65, {6'b000010, 3'd7, 2'd3, 4'd1});
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (69) tick();
    chk("done_hold", 32'(obs_vec()), 32'({6'b0, 3'd7, 2'd3, 4'd1}));
    i_pause = 1'b1;
    repeat (3) tick();
    i_pause = 1'b0;
    chk("pause_in_done", 32'(obs_vec()), 32'({6'b0, 3'd7, 2'd3, 4'd1}));

    // Loop back to bar 1, twice, never song_end
    i_loop_en        = 1'b1;
    i_loop_start_bar = 4'd1;
    c0 = cyc;
    push_seq(c0, 100, 1, 1, 1'b1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (99) tick();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    i_loop_en = 1'b0;
    chk("stop_after_loop", 32'(obs_vec()), 32'd0);

    // Pause for 37 cycles between strobes: gap becomes 10+37
    i_tick_div = 24'd10;
    c0 = cyc;
    push(c0 + 1, pos_vec(0));
    push(c0 + 11, pos_vec(1));
    push(c0 + 21, pos_vec(2));
    push(c0 + 68, pos_vec(3));
    push(c0 + 78, pos_vec(4));
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (25) tick();
    i_pause = 1'b1;
    repeat (37) tick();
    chk("paused_running", 32'(o_running), 32'd1);
    chk("paused_subtick", 32'(o_subtick), 32'd2);
    i_pause = 1'b0;
    repeat (17) tick();
    i_start = 1'b1;
    i_stop  = 1'b1;
    tick();
    i_start = 1'b0;
    i_stop  = 1'b0;
    chk("start_stop_idle", 32'(obs_vec()), 32'd0);

`ifdef TEMPO_TRANSPORT_SWING_EN
    // Swing: row 0 every 4 cycles, row 1 every 6
    i_tick_div   = 24'd4;
    i_swing_clks = 24'd2;
    c0 = cyc;
    push_seq(c0, 12, 4, 6, 1'b0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (52) tick();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    i_swing_clks = 24'd0;
    chk("swing_stop", 32'(obs_vec()), 32'd0);
`endif

    repeat (3) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tempo_transport.md
Name: tempo_transport

Overview:
Transport controller and tick scheduler for the song player. It replaces the free-running tick clock divider with a programmable, start/stop/pause-able sub-tick sequencer. It emits single-cycle strobes for sub-tick, row, gate-on and gate-off, and it tracks the song position (bar/row/sub-tick) with loop support. It runs in the main clock domain, and its strobes drive the song player's row stepping and envelope gating.

Parameters:
SUBTICKS, 8, sub-ticks per row (power of 2, ≥2)
ROWS_PER_BAR, 16, rows per bar (power of 2)
BAR_BITS, 4, width of bar counter
DIV_BITS, 24, width of tick_div (clocks per sub-tick)
GATE_OFF_SUB, 6, sub-tick index at which gate_off_stb fires (< SUBTICKS)

Ports:
clk  in  1  main clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: (re)start playback at bar 0
stop  in  1  pulse: halt and clear position
pause  in  1  level: freeze while high
tick_div  in  DIV_BITS  clocks per sub-tick
loop_en  in  1  loop at end bar instead of finishing
loop_start_bar  in  BAR_BITS  bar to jump to when looping
loop_end_bar  in  BAR_BITS  last bar played
subtick_stb  out  1  one-cycle sub-tick strobe
row_stb  out  1  subtick_stb on sub-tick 0
gate_on_stb  out  1  equals row_stb
gate_off_stb  out  1  subtick_stb on sub-tick GATE_OFF_SUB
subtick  out  log2(SUBTICKS)  current sub-tick
row  out  log2(ROWS_PER_BAR)  current row
bar  out  BAR_BITS  current bar
running  out  1  high in RUN or PAUSE
song_end  out  1  one-cycle pulse on finish

Behaviour:
- Reset: state IDLE; all strobes, song_end and running are 0; subtick, row and bar are 0; the divider counter is 0.
- States are IDLE, RUN, PAUSE and DONE. All outputs are registered.
- Command priority: stop > start > pause.
- stop from any state → IDLE on the next cycle. Position and counter clear to 0, and no strobe is issued.
- start from any state other than a simultaneous stop → RUN:
  - Position is set to 0/0/0.
  - subtick_stb, row_stb and gate_on_stb assert on the cycle after start (latency 1).
  - The counter loads period−1.
- Period: period = tick_div, sampled at every counter reload. tick_div=0 is treated as 1 (a strobe every cycle).
- In RUN the counter decrements each cycle. When it reaches 0:
  - The counter reloads.
  - Position advances by one sub-tick, carrying sub-tick→row→bar (bar wraps modulo 2^BAR_BITS).
  - subtick_stb asserts for 1 cycle. The position outputs show the new position in the same cycle as the strobe.
- End condition: the counter expires while the position is (loop_end_bar, ROWS_PER_BAR−1, SUBTICKS−1).
  - If loop_en=1: the position becomes (loop_start_bar, 0, 0) with normal strobes. This applies even if loop_start_bar > loop_end_bar.
  - If loop_en=0: → DONE. song_end pulses for 1 cycle, no strobe is issued, running drops, and the position holds the last value.
- pause=1 in RUN → PAUSE next cycle; counter and position freeze, no strobes.
- pause=0 in PAUSE → RUN; the counter continues from its frozen value (no lost or extra strobe).
- pause has no effect in IDLE or DONE.
- loop inputs are sampled only at the end-condition cycle.
- DONE and IDLE both wait for start.

Optional Feature:
TEMPO_TRANSPORT_SWING_EN:
- Defined: adds input swing_clks (DIV_BITS). Each sub-tick of an odd-numbered row uses period tick_div+swing_clks (saturating at all-ones); even rows use tick_div. Zero swing_clks gives behaviour identical to undefined.
- Undefined: the port is absent and all rows use a uniform period.

Test Plan:
1. Reset with rst_n=0 mid-run, tick_div=4 → all outputs 0 immediately (async), state IDLE. Release and wait 20 cycles → no strobes.
2. SUBTICKS=8, tick_div=4, start pulse at cycle 0:
   - row_stb and subtick_stb at cycle 1.
   - Subsequent subtick_stb at cycles 5, 9, …
   - gate_off_stb at cycle 25 (sub-tick 6).
   - Next row_stb at cycle 33 with row=1.
3. ROWS_PER_BAR=4, loop_en=0, loop_end_bar=1, tick_div=1 → song_end pulses once after exactly 64 sub-ticks; running=0; bar=1, row=3, subtick=7 held.
4. Same setup with loop_en=1 and loop_start_bar=1 → after bar 1's last sub-tick, the next strobe shows bar=1, row=0, subtick=0, and song_end never asserts.
5. tick_div=10, pause high for 37 cycles midway between strobes → strobe spacing across the pause is 10+37 cycles, with no missed or duplicate positions. start and stop asserted together → IDLE with no strobe.
6. (SWING_EN) tick_div=4, swing_clks=2 → row 0 sub-ticks spaced 4 cycles apart, row 1 spaced 6 cycles apart.
